addsub_pipe: RTL and testbench

Parametrised pipelined adder/subtractor. Successor to the fixed 32-bit, 4-stage pipelined adder, now generic in width and depth, with add/subtract mode, a valid tag, and optional signed-overflow detection. It sits in the datapath anywhere a registered, stallable wide add is needed. One result is produced per unstalled clock at fixed latency.

---
 rtl/addsub_pipe_pkg.sv | 25 ++
 rtl/addsub_pipe_if.sv | 45 ++++
 rtl/addsub_pipe_slice.sv | 81 ++++++++
 rtl/addsub_pipe.sv | 152 +++++++++++++++
 tb/tb_addsub_pipe.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared constants and elaboration helpers for the pipelined
//               adder/subtractor (addsub_pipe) and its per-stage slice.
//               Build option: ADDSUB_PIPE_OVF_EN (consumed by addsub_pipe).
// Contents    : ADDSUB_ADD / ADDSUB_SUB mode encodings,
//               addsub_cfg_ok() geometry check for WIDTH / STAGES.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  // Encoding of the 'sub' mode input.
  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;

  // The carry chain is split into equal slices, one per stage, so the
  // width has to divide evenly and there must be at least one stage.
  function automatic bit addsub_cfg_ok(input int unsigned width,
                                       input int unsigned stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe_if
// Description : Operand / result bundle of the pipelined adder/subtractor.
//               The master drives operands and the stall, the slave (the
//               pipeline) drives the result.
// Signals     : stop      - stall, freezes the whole pipeline
//               in_valid  - qualifies a, b, cin, sub
//               a, b      - operands (WIDTH bits)
//               cin       - carry-in (add) / borrow-in (subtract)
//               sub       - 0 = add, 1 = subtract
//               out_valid - result valid
//               sum       - result (WIDTH bits)
//               cout      - carry-out (subtract: 1 = no borrow)
//               ovf       - signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);

  logic             stop;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output stop, in_valid, a, b, cin, sub,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  stop, in_valid, a, b, cin, sub,
    output out_valid, sum, cout, ovf
  );

endinterface
`default_nettype wire

// File: rtl/addsub_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module      : addsub_slice
// Description : One stage of the pipelined adder. Adds an SW-bit slice of the
//               (already skew-aligned) operands with the carry handed over by
//               the previous stage and registers the result slice and the
//               carry-out. Optionally registers the signed-overflow flag of
//               the full word when this slice holds the sign bit.
// Parameters  : SW     - slice width in bits
//               OVF_EN - build the overflow flag register in this slice
// Ports       : clk, rst (synchronous, active-low), stop_i (stall)
//               a_i, b_i  - operand slices (b_i already inverted for subtract)
//               c_i       - carry into this slice
//               ovf_i     - overflow flag from the previous stage
//               sum_o     - registered result slice
//               c_o       - registered carry-out
//               ovf_o     - overflow flag towards the next stage / output
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SW     = 8,
  parameter bit OVF_EN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stop_i,
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  input  logic          ovf_i,
  output logic [SW-1:0] sum_o,
  output logic          c_o,
  output logic          ovf_o
);

  logic [SW:0]   add_d;
  logic [SW-1:0] sum_q;
  logic          c_q;

  assign add_d = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= '0;
      c_q   <= 1'b0;
    end else if (!stop_i) begin
      sum_q <= add_d[SW-1:0];
      c_q   <= add_d[SW];
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;

  if (OVF_EN) begin : g_ovf
    logic ovf_d;
    logic ovf_q;

    // Operands of equal sign producing a result of the other sign. The
    // incoming flag is OR-ed in so the chain from lower stages stays
    // connected (it is constant zero there).
    assign ovf_d = ovf_i |
                   ((a_i[SW-1] == b_i[SW-1]) && (add_d[SW-1] != a_i[SW-1]));

    always_ff @(posedge clk) begin
      if (!rst) begin
        ovf_q <= 1'b0;
      end else if (!stop_i) begin
        ovf_q <= ovf_d;
      end
    end

    assign ovf_o = ovf_q;
  end else begin : g_no_ovf
    assign ovf_o = ovf_i;
  end

endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe
// Description : Parametrised pipelined adder/subtractor. Stage k resolves
//               bit slice k of the carry chain; upper operand slices are
//               skewed through delay registers and finished lower result
//               slices are de-skewed so the whole word leaves aligned.
//               One result per unstalled clock, latency STAGES.
// Build opt.  : ADDSUB_PIPE_OVF_EN - when defined, signed-overflow logic and
//               its pipeline bit are built; otherwise ovf is tied to 0.
// Parameters  : WIDTH  - operand/result width (multiple of STAGES)
//               STAGES - pipeline depth (>= 1)
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-low reset, priority over stall
//               bus  - addsub_pipe_if.slave (stop, in_valid, a, b, cin,
//                      sub in; out_valid, sum, cout, ovf out)
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

`ifdef ADDSUB_PIPE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  if (!addsub_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("addsub_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  // Subtract is a + ~b + ~cin; the inversion happens once at the input so
  // mode and carry travel with the operands and may change every cycle.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = (bus.sub == ADDSUB_SUB) ? ~bus.b   : bus.b;
  assign c_eff = (bus.sub == ADDSUB_SUB) ? ~bus.cin : bus.cin;

  // carry[k] feeds stage k; carry[STAGES] is the final carry-out.
  logic [STAGES:0]           carry;
  logic [STAGES:0]           ovf_chain;
  logic [STAGES-1:0][SW-1:0] slice_sum;
  logic [WIDTH-1:0]          sum_w;

  assign carry[0]     = c_eff;
  assign ovf_chain[0] = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] a_op;
    logic [SW-1:0] b_op;

    // ---- operand skew: slice k waits k cycles for its carry ----
    if (k == 0) begin : g_direct
      assign a_op = bus.a[SW-1:0];
      assign b_op = b_eff[SW-1:0];
    end else begin : g_skew
      logic [SW-1:0] a_skew_q [k];
      logic [SW-1:0] b_skew_q [k];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int j = 0; j < k; j++) begin
            a_skew_q[j] <= '0;
            b_skew_q[j] <= '0;
          end
        end else if (!bus.stop) begin
          a_skew_q[0] <= bus.a[k*SW +: SW];
          b_skew_q[0] <= b_eff[k*SW +: SW];
          for (int j = 1; j < k; j++) begin
            a_skew_q[j] <= a_skew_q[j-1];
            b_skew_q[j] <= b_skew_q[j-1];
          end
        end
      end

      assign a_op = a_skew_q[k-1];
      assign b_op = b_skew_q[k-1];
    end

    // Only the slice holding the sign bit builds the overflow register.
    addsub_slice #(
      .SW     (SW),
      .OVF_EN (OVF_EN && (k == STAGES - 1))
    ) u_slice (
      .clk    (clk),
      .rst    (rst),
      .stop_i (bus.stop),
      .a_i    (a_op),
      .b_i    (b_op),
      .c_i    (carry[k]),
      .ovf_i  (ovf_chain[k]),
      .sum_o  (slice_sum[k]),
      .c_o    (carry[k+1]),
      .ovf_o  (ovf_chain[k+1])
    );

    // ---- result de-skew: finished slice k waits for the upper slices ----
    if (k == STAGES - 1) begin : g_last
      assign sum_w[k*SW +: SW] = slice_sum[k];
    end else begin : g_deskew
      localparam int DEPTH = STAGES - 1 - k;
      logic [SW-1:0] dsk_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int j = 0; j < DEPTH; j++) begin
            dsk_q[j] <= '0;
          end
        end else if (!bus.stop) begin
          dsk_q[0] <= slice_sum[k];
          for (int j = 1; j < DEPTH; j++) begin
            dsk_q[j] <= dsk_q[j-1];
          end
        end
      end

      assign sum_w[k*SW +: SW] = dsk_q[DEPTH-1];
    end
  end

  // Valid tag rides alongside the data, one bit per stage.
  logic [STAGES-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (!bus.stop) begin
      valid_q[0] <= bus.in_valid;
      for (int j = 1; j < STAGES; j++) begin
        valid_q[j] <= valid_q[j-1];
      end
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = sum_w;
  assign bus.cout      = carry[STAGES];
  assign bus.ovf       = ovf_chain[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_pipe
// Description : Self-checking bench for addsub_pipe. A 32-bit / 4-stage
//               instance is fed through a scoreboard (expected results are
//               queued when an operation is accepted and compared when
//               out_valid appears); an 8-bit / 1-stage instance is exercised
//               with directed steps. Honours ADDSUB_PIPE_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;

`ifdef ADDSUB_PIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  addsub_pipe_if #(.WIDTH(32)) bus ();
  addsub_pipe_if #(.WIDTH(8))  bus8 ();

  addsub_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  addsub_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  int   n_exp   = 0;
  int   n_out   = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain a+b+cin, or a-b-cin with borrow -> cout=0.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
    logic [32:0] r;
    exp_t        e;
    if (!s) begin
      r      = {1'b0, a} + {1'b0, b} + {32'd0, c};
      e.cout = r[32];
      e.ovf  = OVF_ON && (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r      = {1'b0, a} - {1'b0, b} - {32'd0, c};
      e.cout = ~r[32];
      e.ovf  = OVF_ON && (a[31] != b[31]) && (r[31] != a[31]);
    end
    e.sum = r[31:0];
    return e;
  endfunction

  // One cycle on the 32-bit DUT; inputs set just after an edge.
  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic s,
                       input logic st);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.sub      = s;
    bus.stop     = st;
    if (v && !st && rst) begin
      sb_q.push_back(model(a, b, c, s));
      n_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic d8(input logic v, input logic [7:0] a, input logic [7:0] b,
                    input logic c, input logic s, input logic st);
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = c;
    bus8.sub      = s;
    bus8.stop     = st;
    @(posedge clk);
    #1;
  endtask

  // ---- output monitor / scoreboard for the 32-bit DUT ----
  logic        mon_stop;
  logic        mon_rst;
  logic        have_prev = 1'b0;
  logic [31:0] prev_sum;
  logic        prev_cout;
  logic        prev_ovf;
  logic        prev_valid;
  exp_t        mon_e;

  always begin
    @(posedge clk);
    mon_stop = bus.stop;
    mon_rst  = rst;
    #2;
    if (!mon_rst) begin
      have_prev = 1'b0;
    end else begin
      if (mon_stop) begin
        if (have_prev) begin
          chk("stall_hold_sum",   bus.sum,       prev_sum);
          chk("stall_hold_cout",  bus.cout,      prev_cout);
          chk("stall_hold_ovf",   bus.ovf,       prev_ovf);
          chk("stall_hold_valid", bus.out_valid, prev_valid);
        end
      end else if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", bus.sum, 64'hDEAD_0000_0000);
        end else begin
          mon_e = sb_q.pop_front();
          n_out++;
          chk("sb_sum",  bus.sum,  mon_e.sum);
          chk("sb_cout", bus.cout, mon_e.cout);
          chk("sb_ovf",  bus.ovf,  mon_e.ovf);
        end
      end
      prev_sum   = bus.sum;
      prev_cout  = bus.cout;
      prev_ovf   = bus.ovf;
      prev_valid = bus.out_valid;
      have_prev  = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.stop = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.cin = 1'b0; bus.sub = 1'b0;
    bus8.stop = 1'b0; bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0;
    bus8.cin = 1'b0; bus8.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state of both instances.
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sum",   bus.sum,       0);
    chk("rst_cout",  bus.cout,      0);
    chk("rst_ovf",   bus.ovf,       0);
    chk("rst8_valid", bus8.out_valid, 0);
    chk("rst8_sum",   bus8.sum,       0);

    // Latency: 1+1 accepted on the first edge after reset release,
    // visible after the fourth edge.
    rst = 1'b1;
    drive(1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("lat_e1", bus.out_valid, 0);
    idle(1); chk("lat_e2", bus.out_valid, 0);
    idle(1); chk("lat_e3", bus.out_valid, 0);
    idle(1); chk("lat_e4", bus.out_valid, 1);
    chk("lat_sum", bus.sum, 32'h2);
    idle(2);

    // Directed corner cases, back to back.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Random mix including bubbles and stalls.
    for (int i = 0; i < 30; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0));
    end
    idle(6);

    // Stall mid-stream: 8 ops a=i, b=1 with two stalled cycles whose
    // (valid-looking) inputs must be ignored.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        drive(1'b1, 32'hAAAA_0000, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h5555_0000, 32'h8765_4321, 1'b0, 1'b1, 1'b1);
      end
      drive(1'b1, 32'(i), 32'h1, 1'b0, 1'b0, 1'b0);
    end
    idle(6);
    chk("stall_sb_empty", sb_q.size(), 0);

    // Reset with three ops in flight, stop also high on that edge.
    drive(1'b1, 32'd10, 32'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd20, 32'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd30, 32'd3, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.stop = 1'b1;
    bus.a = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    n_exp = n_exp - sb_q.size();
    sb_q.delete();
    rst = 1'b1;
    bus.stop = 1'b0;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_sum",   bus.sum,       0);
    chk("mrst_cout",  bus.cout,      0);
    chk("mrst_ovf",   bus.ovf,       0);
    drive(1'b1, 32'd100, 32'd23, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("mrst_new_valid", bus.out_valid, 1);
    chk("mrst_new_sum",   bus.sum,       32'd123);
    idle(3);

    // 8-bit, single-stage instance: latency 1.
    d8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("s1_ff01_sum",   bus8.sum,       8'h00);
    chk("s1_ff01_cout",  bus8.cout,      1);
    chk("s1_ff01_valid", bus8.out_valid, 1);
    d8(1'b1, 8'h03, 8'h05, 1'b0, 1'b1, 1'b0);
    chk("s1_sub_sum",  bus8.sum,  8'hFE);
    chk("s1_sub_cout", bus8.cout, 0);
    d8(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("s1_stall_sum",   bus8.sum,       8'hFE);
    chk("s1_stall_valid", bus8.out_valid, 1);
    d8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("s1_ovf_sum", bus8.sum, 8'h80);
    chk("s1_ovf",     bus8.ovf, OVF_ON);
    d8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("s1_bubble_valid", bus8.out_valid, 0);
    d8(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    chk("s1_pre_rst_sum", bus8.sum, 8'h30);
    bus8.in_valid = 1'b1;
    bus8.a        = 8'h44;
    bus8.stop     = 1'b1;
    rst           = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("s1_rst_sum",   bus8.sum,       0);
    chk("s1_rst_cout",  bus8.cout,      0);
    chk("s1_rst_ovf",   bus8.ovf,       0);
    chk("s1_rst_valid", bus8.out_valid, 0);
    d8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("s1_post_sum",   bus8.sum,       8'h00);
    chk("s1_post_cout",  bus8.cout,      1);
    chk("s1_post_valid", bus8.out_valid, 1);
    d8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    idle(2);
    chk("sb_empty", sb_q.size(), 0);
    chk("n_out",    n_out,       n_exp);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
